// File: rtl/id_ex_operand_stage_pkg.sv
// id_ex_operand_stage_pkg: widths, ALU op codes and legality check for the ID->EX operand stage
package id_ex_operand_stage_pkg;
    localparam int XLEN = 32;
    localparam int RADDR_W = 5;
    localparam int OP_W = 4;
    localparam int CNT_W = 32;
    typedef enum logic [OP_W-1:0] {
        ALU_ADD = 4'b0000,
        ALU_SUB = 4'b0001,
        ALU_XOR = 4'b0010,
        ALU_OR  = 4'b0011
    } alu_op_t;
    function automatic logic is_legal_alu_op(input logic [OP_W-1:0] op);
        return op inside {ALU_ADD, ALU_SUB, ALU_XOR, ALU_OR};
    endfunction
endpackage

// File: rtl/id_ex_operand_stage_if.sv
// id_ex_operand_stage_if: decode-side inputs, forwarding taps and ALU-side outputs of the operand stage
interface id_ex_operand_stage_if;
    import id_ex_operand_stage_pkg::*;
    logic inValid;
    logic inReady;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1Data;
    logic [XLEN-1:0] rs2Data;
    logic [XLEN-1:0] imm;
    logic [RADDR_W-1:0] rs1Addr;
    logic [RADDR_W-1:0] rs2Addr;
    logic [RADDR_W-1:0] rdAddr;
    logic opASel;
    logic opBSel;
    logic [OP_W-1:0] aluOp;
    logic regWrite;
    logic exFwdValid;
    logic [RADDR_W-1:0] exFwdRd;
    logic [XLEN-1:0] exFwdData;
    logic exIsLoad;
    logic memFwdValid;
    logic [RADDR_W-1:0] memFwdRd;
    logic [XLEN-1:0] memFwdData;
    logic flush;
    logic outValid;
    logic outReady;
    logic [XLEN-1:0] opA;
    logic [XLEN-1:0] opB;
    logic [OP_W-1:0] aluOutSel;
    logic [RADDR_W-1:0] rdOut;
    logic regWriteOut;
    logic illegalOp;
    logic [CNT_W-1:0] stallCount;
    modport master (
        output inValid, pc, rs1Data, rs2Data, imm, rs1Addr, rs2Addr, rdAddr, opASel, opBSel,
               aluOp, regWrite, exFwdValid, exFwdRd, exFwdData, exIsLoad, memFwdValid,
               memFwdRd, memFwdData, flush, outReady,
        input  inReady, outValid, opA, opB, aluOutSel, rdOut, regWriteOut, illegalOp, stallCount
    );
    modport slave (
        input  inValid, pc, rs1Data, rs2Data, imm, rs1Addr, rs2Addr, rdAddr, opASel, opBSel,
               aluOp, regWrite, exFwdValid, exFwdRd, exFwdData, exIsLoad, memFwdValid,
               memFwdRd, memFwdData, flush, outReady,
        output inReady, outValid, opA, opB, aluOutSel, rdOut, regWriteOut, illegalOp, stallCount
    );
endinterface

// File: rtl/id_ex_operand_stage_fwd_mux.sv
// id_ex_operand_stage_fwd_mux: picks EX (non-load) over MEM over regfile for one source; x0 never forwards
module id_ex_operand_stage_fwd_mux
    import id_ex_operand_stage_pkg::*;
(
    input  logic [RADDR_W-1:0] rs_addr,
    input  logic [XLEN-1:0]    rs_data,
    input  logic               ex_valid,
    input  logic               ex_is_load,
    input  logic [RADDR_W-1:0] ex_rd,
    input  logic [XLEN-1:0]    ex_data,
    input  logic               mem_valid,
    input  logic [RADDR_W-1:0] mem_rd,
    input  logic [XLEN-1:0]    mem_data,
    output logic [XLEN-1:0]    value
);
    logic ex_hit, mem_hit;
    assign ex_hit = ex_valid && !ex_is_load && ex_rd == rs_addr;
    assign mem_hit = mem_valid && mem_rd == rs_addr;
    assign value = rs_addr == '0 ? rs_data : ex_hit ? ex_data : mem_hit ? mem_data : rs_data;
endmodule

// File: rtl/id_ex_operand_stage.sv
// id_ex_operand_stage: ID->EX register with operand forwarding, load-use stall and flush
module id_ex_operand_stage
    import id_ex_operand_stage_pkg::*;
(
    input logic clk,
    input logic rst,
    id_ex_operand_stage_if.slave bus
);
    logic hazard, xfer, legal;
    logic [XLEN-1:0] rs1_val, rs2_val;
    id_ex_operand_stage_fwd_mux u_fwd_rs1 (
        .rs_addr(bus.rs1Addr), .rs_data(bus.rs1Data),
        .ex_valid(bus.exFwdValid), .ex_is_load(bus.exIsLoad), .ex_rd(bus.exFwdRd), .ex_data(bus.exFwdData),
        .mem_valid(bus.memFwdValid), .mem_rd(bus.memFwdRd), .mem_data(bus.memFwdData),
        .value(rs1_val)
    );
    id_ex_operand_stage_fwd_mux u_fwd_rs2 (
        .rs_addr(bus.rs2Addr), .rs_data(bus.rs2Data),
        .ex_valid(bus.exFwdValid), .ex_is_load(bus.exIsLoad), .ex_rd(bus.exFwdRd), .ex_data(bus.exFwdData),
        .mem_valid(bus.memFwdValid), .mem_rd(bus.memFwdRd), .mem_data(bus.memFwdData),
        .value(rs2_val)
    );
    // only sources actually read from the regfile can collide with a pending load
    assign hazard = bus.exIsLoad && bus.exFwdValid && bus.exFwdRd != '0 &&
                    ((!bus.opASel && bus.rs1Addr == bus.exFwdRd) || (!bus.opBSel && bus.rs2Addr == bus.exFwdRd));
    assign bus.inReady = (!bus.outValid || bus.outReady) && !hazard && !bus.flush;
    assign xfer = bus.inValid && bus.inReady;
    assign legal = is_legal_alu_op(bus.aluOp);
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.outValid <= 1'b0;
            bus.opA <= '0;
            bus.opB <= '0;
            bus.aluOutSel <= '0;
            bus.rdOut <= '0;
            bus.regWriteOut <= 1'b0;
            bus.illegalOp <= 1'b0;
            bus.stallCount <= '0;
        end else begin
            if (bus.flush) begin
                bus.outValid <= 1'b0;
            end else if (xfer) begin
                bus.outValid <= 1'b1;
                bus.opA <= bus.opASel ? bus.pc : rs1_val;
                bus.opB <= bus.opBSel ? bus.imm : rs2_val;
                bus.aluOutSel <= legal ? bus.aluOp : ALU_ADD;
                bus.rdOut <= bus.rdAddr;
                bus.regWriteOut <= bus.regWrite && legal;
                bus.illegalOp <= !legal;
            end else if (bus.outReady) begin
                bus.outValid <= 1'b0;
            end
            if (bus.inValid && hazard && !bus.flush && !(&bus.stallCount))
                bus.stallCount <= bus.stallCount + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_id_ex_operand_stage.sv
// tb_id_ex_operand_stage: randomized scoreboard bench with a behavioural model of the operand stage
module tb_id_ex_operand_stage;
    import id_ex_operand_stage_pkg::*;
    typedef struct {
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [OP_W-1:0] sel;
        logic [RADDR_W-1:0] rd;
        logic rw;
        logic ill;
    } exp_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    exp_t q[$];
    logic m_valid = 1'b0;
    logic [CNT_W-1:0] m_stall = '0;
    id_ex_operand_stage_if bus ();
    id_ex_operand_stage dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    function automatic logic [XLEN-1:0] ref_src(input logic [RADDR_W-1:0] addr, input logic [XLEN-1:0] data);
        if (addr == 0) return data;
        if (bus.exFwdValid && !bus.exIsLoad && bus.exFwdRd == addr) return bus.exFwdData;
        if (bus.memFwdValid && bus.memFwdRd == addr) return bus.memFwdData;
        return data;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic idle();
        bus.inValid = 0; bus.flush = 0; bus.outReady = 1;
        bus.pc = 0; bus.rs1Data = 0; bus.rs2Data = 0; bus.imm = 0;
        bus.rs1Addr = 0; bus.rs2Addr = 0; bus.rdAddr = 0; bus.opASel = 0; bus.opBSel = 0;
        bus.aluOp = 0; bus.regWrite = 0; bus.exFwdValid = 0; bus.exFwdRd = 0; bus.exFwdData = 0;
        bus.exIsLoad = 0; bus.memFwdValid = 0; bus.memFwdRd = 0; bus.memFwdData = 0;
    endtask

    // settle, compare handshake/state against the model, then advance one clock
    task automatic step();
        logic hz, rdy, xfer;
        exp_t e;
        #1;
        hz = bus.exIsLoad && bus.exFwdValid && bus.exFwdRd != 0 &&
             ((!bus.opASel && bus.rs1Addr == bus.exFwdRd) || (!bus.opBSel && bus.rs2Addr == bus.exFwdRd));
        rdy = (!m_valid || bus.outReady) && !hz && !bus.flush;
        check("in_ready", 64'(bus.inReady), 64'(rdy));
        check("out_valid", 64'(bus.outValid), 64'(m_valid));
        check("stall_count", 64'(bus.stallCount), 64'(m_stall));
        xfer = bus.inValid && rdy;
        if (xfer) begin
            e.a = bus.opASel ? bus.pc : ref_src(bus.rs1Addr, bus.rs1Data);
            e.b = bus.opBSel ? bus.imm : ref_src(bus.rs2Addr, bus.rs2Data);
            e.ill = bus.aluOp > 3;
            e.sel = e.ill ? 4'd0 : bus.aluOp;
            e.rw = bus.regWrite && !e.ill;
            e.rd = bus.rdAddr;
            q.push_back(e);
        end
        if (bus.inValid && hz && !bus.flush && m_stall != '1) m_stall++;
        m_valid = bus.flush ? 1'b0 : xfer ? 1'b1 : bus.outReady ? 1'b0 : m_valid;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst && bus.outValid) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL out_unexpected actual=valid required=empty");
            end else begin
                if (!bus.flush) begin
                    check("out_opA", 64'(bus.opA), 64'(q[0].a));
                    check("out_opB", 64'(bus.opB), 64'(q[0].b));
                    check("out_ctl", {53'd0, bus.aluOutSel, bus.rdOut, bus.regWriteOut, bus.illegalOp},
                          {53'd0, q[0].sel, q[0].rd, q[0].rw, q[0].ill});
                end
                if (bus.outReady || bus.flush) void'(q.pop_front());
            end
        end
    end

    initial begin
        idle();
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        check("rst_outs", {bus.opA, bus.opB}, 64'd0);
        check("rst_ctl", {bus.outValid, bus.aluOutSel, bus.rdOut, bus.regWriteOut, bus.illegalOp}, 64'd0);
        check("rst_stall", 64'(bus.stallCount), 64'd0);
        step();
        // basic capture
        bus.inValid = 1; bus.rs1Data = 5; bus.rs2Data = 3; bus.aluOp = 4'b0001;
        bus.rs1Addr = 1; bus.rs2Addr = 2; bus.rdAddr = 3; bus.regWrite = 1;
        step();
        // EX beats MEM on the same index; then x0 never forwards
        bus.rs1Addr = 7; bus.rs1Data = 32'h11; bus.exFwdValid = 1; bus.exFwdRd = 7; bus.exFwdData = 32'hAA;
        bus.memFwdValid = 1; bus.memFwdRd = 7; bus.memFwdData = 32'hBB;
        step();
        bus.rs1Addr = 0; bus.exFwdRd = 0; bus.memFwdRd = 0; bus.rs1Data = 32'h1234;
        step();
        idle();
        step();
        // load-use stall then release
        bus.inValid = 1; bus.rs2Addr = 4; bus.rs2Data = 9; bus.exIsLoad = 1; bus.exFwdValid = 1;
        bus.exFwdRd = 4; bus.exFwdData = 32'hDEAD;
        step();
        step();
        bus.exIsLoad = 0;
        step();
        idle();
        // backpressure: held item must stay stable, new input refused
        bus.inValid = 1; bus.pc = 32'h100; bus.opASel = 1; bus.imm = 32'h44; bus.opBSel = 1;
        bus.aluOp = 4'b0010;
        step();
        bus.outReady = 0; bus.pc = 32'h200; bus.aluOp = 4'b0011;
        step();
        step();
        bus.outReady = 1;
        step();
        // flush drops the held item and the concurrent input
        bus.outReady = 0;
        step();
        bus.flush = 1;
        step();
        bus.flush = 0; bus.inValid = 0; bus.outReady = 1;
        step();
        // illegal op
        bus.inValid = 1; bus.aluOp = 4'b1010; bus.regWrite = 1;
        step();
        idle();
        step();
        for (int i = 0; i < 400; i++) begin
            bus.inValid = $urandom_range(0, 9) < 8;
            bus.flush = $urandom_range(0, 9) == 0;
            bus.outReady = $urandom_range(0, 9) < 7;
            bus.pc = $urandom; bus.rs1Data = $urandom; bus.rs2Data = $urandom; bus.imm = $urandom;
            bus.rs1Addr = 5'($urandom_range(0, 7)); bus.rs2Addr = 5'($urandom_range(0, 7));
            bus.rdAddr = 5'($urandom_range(0, 31)); bus.opASel = 1'($urandom); bus.opBSel = 1'($urandom);
            bus.aluOp = $urandom_range(0, 9) < 7 ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
            bus.regWrite = 1'($urandom);
            bus.exFwdValid = 1'($urandom); bus.exFwdRd = 5'($urandom_range(0, 7)); bus.exFwdData = $urandom;
            bus.exIsLoad = $urandom_range(0, 9) < 3;
            bus.memFwdValid = 1'($urandom); bus.memFwdRd = 5'($urandom_range(0, 7)); bus.memFwdData = $urandom;
            step();
        end
        idle();
        repeat (3) step();
        check("queue_drained", 64'(q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
